fetcher: RTL and testbench

- Instruction-fetch front end. Feeds the decode stage.
- Holds the PC and issues one-instruction fetch requests to the memory controller through a req/done handshake.
- Buffers returned instructions in a small FIFO and presents the head as instPC/inst/DecEn to the decoder.
- On a branch mispredict (mistaken) it flushes the FIFO, cancels any in-flight response and restarts at jumpAddr.

---
 rtl/fetcher_pkg.sv | 21 ++
 rtl/fetcher_inst_queue.sv | 77 +++++++
 rtl/fetcher.sv | 138 +++++++++++++
 tb/tb_fetcher.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetcher_pkg.sv
// rtl/fetcher_pkg.sv - shared types and widths for the instruction-fetch front end
package fetcher_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_ADDR_W-1:0] PC_STEP          = 32'd4;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_t;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetcher_inst_queue.sv
// rtl/fetcher_inst_queue.sv - circular FIFO of {pc, inst} entries
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   en            global ready; when low nothing changes
//   push, data_in write one entry
//   pop           retire the head entry
//   flush         empty the queue and rewind both pointers (wins over push/pop)
//   count         number of valid entries
//   full, empty   count == BUF_DEPTH / count == 0
//   head          head entry, all zero when empty
module fetcher_inst_queue
    import fetcher_pkg::*;
#(
    parameter int BUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          push,
    input  fetch_entry_t                  data_in,
    input  logic                          pop,
    input  logic                          flush,
    output logic [$clog2(BUF_DEPTH):0]    count,
    output logic                          full,
    output logic                          empty,
    output fetch_entry_t                  head
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t      storage [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == CNT_W'(BUF_DEPTH));
    assign empty = (count == '0);

    // A push into a full queue is only legal when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            end
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (rst && en && !flush && do_push) begin
            storage[wr_ptr] <= data_in;
        end
    end

    assign head = empty ? '0 : storage[rd_ptr];

endmodule

// File: rtl/fetcher.sv
// rtl/fetcher.sv - instruction-fetch front end: PC, fetch FSM, mispredict recovery
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   rdy                global ready; low freezes all state
//   stall              decoder cannot accept the head this cycle
//   mistaken, jumpAddr branch mispredict pulse and redirect target
//   memReq, memAddr    fetch request level and address to the memory controller
//   memDone, memInst   one-cycle completion pulse and returned instruction
//   DecEn, instPC, inst head of the instruction buffer towards decode
module fetcher
    import fetcher_pkg::*;
#(
    parameter int                     BUF_DEPTH = 4,
    parameter logic [INST_ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   stall,
    input  logic                   mistaken,
    input  logic [INST_ADDR_W-1:0] jumpAddr,
    output logic                   memReq,
    output logic [INST_ADDR_W-1:0] memAddr,
    input  logic                   memDone,
    input  logic [INST_W-1:0]      memInst,
    output logic                   DecEn,
    output logic [INST_ADDR_W-1:0] instPC,
    output logic [INST_W-1:0]      inst
);

    fetch_state_t              state;
    fetch_state_t              state_n;
    logic [INST_ADDR_W-1:0]    pc;
    logic [INST_ADDR_W-1:0]    pc_n;
    logic                      discard;
    logic                      discard_n;
    logic                      req_n;
    logic [INST_ADDR_W-1:0]    addr_n;

    logic                      q_push;
    logic                      q_pop;
    logic [$clog2(BUF_DEPTH):0] q_count;
    logic                      q_full;
    logic                      q_empty;
    fetch_entry_t              q_data_in;
    fetch_entry_t              q_head;

    // Returned data is kept only if it belongs to the current instruction stream.
    assign q_push    = (state == FETCH_WAIT) && memDone && !discard && !mistaken;
    assign q_pop     = !q_empty && !stall && !mistaken;
    assign q_data_in = '{pc: memAddr, inst: memInst};

    fetcher_inst_queue #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .en      (rdy),
        .push    (q_push),
        .data_in (q_data_in),
        .pop     (q_pop),
        .flush   (mistaken),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty),
        .head    (q_head)
    );

    assign DecEn  = (q_count != '0);
    assign instPC = q_head.pc;
    assign inst   = q_head.inst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= FETCH_IDLE;
            pc      <= RESET_PC;
            discard <= 1'b0;
            memReq  <= 1'b0;
            memAddr <= '0;
        end else if (rdy) begin
            state   <= state_n;
            pc      <= pc_n;
            discard <= discard_n;
            memReq  <= req_n;
            memAddr <= addr_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        discard_n = discard;
        req_n     = memReq;
        addr_n    = memAddr;

        if (mistaken) begin
            pc_n = jumpAddr;
            if (state == FETCH_WAIT) begin
                if (memDone) begin
                    // The response lands together with the redirect: drop it and finish.
                    state_n   = FETCH_IDLE;
                    req_n     = 1'b0;
                    discard_n = 1'b0;
                end else begin
                    // The outstanding response is stale; swallow it when it arrives.
                    discard_n = 1'b1;
                end
            end
        end else begin
            case (state)
                FETCH_IDLE: begin
                    // Fullness uses the registered count, so a pop this cycle cannot free a slot yet.
                    if (!q_full) begin
                        state_n = FETCH_WAIT;
                        req_n   = 1'b1;
                        addr_n  = pc;
                    end
                end
                FETCH_WAIT: begin
                    if (memDone) begin
                        state_n = FETCH_IDLE;
                        req_n   = 1'b0;
                        if (discard) begin
                            discard_n = 1'b0;
                        end else begin
                            pc_n = pc + PC_STEP;
                        end
                    end
                end
                default: begin
                    state_n = FETCH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// tb/tb_fetcher.sv - directed self-checking bench for fetcher
module tb_fetcher;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        stall = 1'b0;
    logic        mistaken = 1'b0;
    logic [31:0] jumpAddr = '0;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memDone = 1'b0;
    logic [31:0] memInst = '0;
    logic        DecEn;
    logic [31:0] instPC;
    logic [31:0] inst;

    int total = 0;
    int bad = 0;

    logic [31:0] req_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];
    logic        busy = 1'b0;
    int          cnt = 0;
    int          lat = 2;
    logic        found;
    int          n_pops;

    fetcher #(
        .BUF_DEPTH (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .stall    (stall),
        .mistaken (mistaken),
        .jumpAddr (jumpAddr),
        .memReq   (memReq),
        .memAddr  (memAddr),
        .memDone  (memDone),
        .memInst  (memInst),
        .DecEn    (DecEn),
        .instPC   (instPC),
        .inst     (inst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: log an accepted pop, advance, then run the memory responder.
    task automatic tick();
        if (rst && rdy && DecEn && !stall && !mistaken) begin
            pop_pc.push_back(instPC);
            pop_inst.push_back(inst);
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            busy    = 1'b0;
            memDone = 1'b0;
        end else if (rdy) begin
            if (memDone) begin
                memDone = 1'b0;
            end else if (memReq && !busy) begin
                busy = 1'b1;
                cnt  = lat;
                req_log.push_back(memAddr);
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    memDone = 1'b1;
                    memInst = memAddr ^ KEY;
                    busy    = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset(input logic stall_val);
        rst      = 1'b0;
        rdy      = 1'b1;
        mistaken = 1'b0;
        stall    = stall_val;
        tick();
        tick();
        req_log.delete();
        pop_pc.delete();
        pop_inst.delete();
        rst = 1'b1;
    endtask

    task automatic wait_reqs(input int n, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (req_log.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (memDone) ok = 1'b1;
        end
    endtask

    task automatic wait_dec(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (DecEn) ok = 1'b1;
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        rdy = 1'b1;
        tick();
        tick();
        check("rst_memReq", memReq, 0);
        check("rst_memAddr", memAddr, 0);
        check("rst_DecEn", DecEn, 0);
        check("rst_instPC", instPC, 0);
        check("rst_inst", inst, 0);

        // Free-running fetch, no stall
        do_reset(1'b0);
        wait_done(found);
        check("t1_done_seen", found, 1);
        check("t1_no_bypass", DecEn, 0);
        tick();
        check("t1_decen", DecEn, 1);
        check("t1_first_pc", instPC, 32'h0);
        check("t1_first_inst", inst, KEY);
        for (int i = 0; i < 40; i++) tick();
        check("t1_nreq", (req_log.size() >= 6), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_req%0d", i), req_log[i], 32'(i * 4));
            check($sformatf("t1_pop_pc%0d", i), pop_pc[i], 32'(i * 4));
            check($sformatf("t1_pop_inst%0d", i), pop_inst[i], 32'(i * 4) ^ KEY);
        end

        // Full buffer under stall
        do_reset(1'b1);
        for (int i = 0; i < 40; i++) tick();
        check("t2_nreq", req_log.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t2_req%0d", i), req_log[i], 32'(i * 4));
        check("t2_memReq_idle", memReq, 0);
        check("t2_head_pc", instPC, 32'h0);
        stall = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("t2_npops", (pop_pc.size() >= 4), 1);
        for (int i = 0; i < 4; i++) check($sformatf("t2_pop%0d", i), pop_pc[i], 32'(i * 4));
        check("t2_req16", req_log[4], 32'h10);

        // Mispredict while waiting on addr 8
        do_reset(1'b1);
        wait_reqs(3, found);
        check("t3_req8_seen", found, 1);
        check("t3_req8_addr", req_log[2], 32'h8);
        mistaken = 1'b1;
        jumpAddr = 32'h100;
        tick();
        mistaken = 1'b0;
        check("t3_flush_decen", DecEn, 0);
        check("t3_wait_held", memReq, 1);
        check("t3_addr_held", memAddr, 32'h8);
        wait_reqs(4, found);
        check("t3_redirect_seen", found, 1);
        check("t3_redirect_addr", req_log[3], 32'h100);
        check("t3_still_empty", DecEn, 0);
        wait_dec(found);
        check("t3_dec_seen", found, 1);
        check("t3_head_pc", instPC, 32'h100);
        check("t3_head_inst", inst, 32'h100 ^ KEY);

        // Mispredict coincident with memDone and a pop
        do_reset(1'b1);
        wait_reqs(2, found);
        check("t4_req4_seen", found, 1);
        wait_done(found);
        check("t4_done_seen", found, 1);
        check("t4_head_before", DecEn, 1);
        stall    = 1'b0;
        mistaken = 1'b1;
        jumpAddr = 32'h200;
        tick();
        mistaken = 1'b0;
        check("t4_empty", DecEn, 0);
        check("t4_empty_pc", instPC, 0);
        check("t4_req_low", memReq, 0);
        wait_reqs(3, found);
        check("t4_redirect_seen", found, 1);
        check("t4_redirect_addr", req_log[2], 32'h200);
        wait_dec(found);
        check("t4_head_pc", instPC, 32'h200);

        // rdy low for 5 cycles mid-WAIT
        do_reset(1'b1);
        wait_reqs(2, found);
        check("t5_req4_seen", found, 1);
        stall  = 1'b0;
        rdy    = 1'b0;
        n_pops = pop_pc.size();
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t5_req_c%0d", i), memReq, 1);
            check($sformatf("t5_addr_c%0d", i), memAddr, 32'h4);
            check($sformatf("t5_dec_c%0d", i), DecEn, 1);
            check($sformatf("t5_pc_c%0d", i), instPC, 32'h0);
        end
        check("t5_no_pops", pop_pc.size(), n_pops);
        rdy = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        check("t5_npops", (pop_pc.size() >= 3), 1);
        for (int i = 0; i < 3; i++) check($sformatf("t5_pop%0d", i), pop_pc[i], 32'(i * 4));

        // Reset while a request is outstanding
        wait_reqs(req_log.size() + 1, found);
        check("t6_wait_seen", found, 1);
        check("t6_req_high", memReq, 1);
        rst = 1'b0;
        tick();
        check("t6_req_low", memReq, 0);
        check("t6_dec_low", DecEn, 0);
        req_log.delete();
        rst = 1'b1;
        wait_reqs(1, found);
        check("t6_req_seen", found, 1);
        check("t6_first_addr", req_log[0], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
